pe_array_ctrl: RTL and testbench

- Sequencer for the PE array: owns the mode, change_mode, op_stage and pe_packet broadcast signals that every PE consumes.
- Per job, it loads a mode and streams filter packets during LOAD_FILTER. It then streams ifmap packets during CONV under per-destination credit flow control, so no PE scratch pad (3 sections) ever overflows.
- It sits between the global buffer read port (valid/ready source) and the PE array.

---
 rtl/pe_array_ctrl_pkg.sv | 31 +++
 rtl/pe_array_ctrl_if.sv | 10 +
 rtl/pe_array_ctrl_credit.sv | 44 ++++
 rtl/pe_array_ctrl.sv | 134 +++++++++++++
 tb/tb_pe_array_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pe_array_ctrl_pkg.sv
// Shared PE-array types: modes, stage broadcast, PE input packet and the
// sequencer state encoding.
package pe_pkg;
  localparam int IFDATA_SIZE    = 8;
  localparam int WDATA_SIZE     = 8;
  localparam int L1_FILTER_SIZE = 3;
  localparam int L2_FILTER_SIZE = 5;
  localparam int L3_FILTER_SIZE = 7;
  localparam int L4_FILTER_SIZE = 9;
  localparam int IDX_W          = 5;

  typedef enum logic [1:0] {MODE1, MODE2, MODE3, MODE4} OP_MODE;
  typedef enum logic [1:0] {IDLE, LOAD_FILTER, CONV} OP_STAGE;

  typedef struct packed {
    logic                     valid;
    logic [IDX_W-1:0]         packet_idx;
    logic [4*IFDATA_SIZE-1:0] data;
  } PE_IN_PACKET;

  typedef enum logic [2:0] {S_IDLE, S_CFG, S_LOAD, S_CONV, S_DONE, S_ERR} CTRL_STATE;

  // Stage seen by the PEs; every non-streaming state broadcasts IDLE.
  function automatic OP_STAGE stage_of(input CTRL_STATE s);
    case (s)
      S_LOAD:  return LOAD_FILTER;
      S_CONV:  return CONV;
      default: return IDLE;
    endcase
  endfunction
endpackage

// File: rtl/pe_array_ctrl_if.sv
// Global-buffer read port feeding the PE array sequencer (valid/ready).
interface pe_array_ctrl_if import pe_pkg::*; ();
  logic                     src_valid;
  logic [4*IFDATA_SIZE-1:0] src_data;
  logic [IDX_W-1:0]         src_idx;
  logic                     src_ready;

  modport master (output src_valid, src_data, src_idx, input src_ready);
  modport slave  (input src_valid, src_data, src_idx, output src_ready);
endinterface

// File: rtl/pe_array_ctrl_credit.sv
// Per-destination scratch-pad credit counters; flags a return into a full counter.
module pe_credit_tracker #(
  parameter int NUM_IDX     = 16,
  parameter int PE_SECTIONS = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IDX-1:0] consume_i,
  input  logic [NUM_IDX-1:0] ret_i,
  output logic [NUM_IDX-1:0] avail_o,
  output logic               ovf_o
);
  localparam int CW = $clog2(PE_SECTIONS + 1);
  localparam logic [CW-1:0] FULL = CW'(PE_SECTIONS);

  logic [NUM_IDX-1:0] ovf;

  for (genvar i = 0; i < NUM_IDX; i++) begin : g_cred
    logic [CW-1:0] cred_q, cred_d;
    logic          of;

    // Consume and return on the same index cancel out.
    always_comb begin
      cred_d = cred_q;
      of     = 1'b0;
      if (consume_i[i] && !ret_i[i]) begin
        if (cred_q != '0) cred_d = cred_q - 1'b1;
      end else if (ret_i[i] && !consume_i[i]) begin
        if (cred_q == FULL) of = 1'b1;
        else                cred_d = cred_q + 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) cred_q <= FULL;
      else      cred_q <= cred_d;
    end

    assign avail_o[i] = (cred_q != '0);
    assign ovf[i]     = of;
  end

  assign ovf_o = |ovf;
endmodule

// File: rtl/pe_array_ctrl.sv
// PE array sequencer: loads the job mode, streams filter packets, then ifmap
// packets under per-destination credit flow control.
module pe_array_ctrl import pe_pkg::*; #(
  parameter int NUM_IDX     = 16,
  parameter int PE_SECTIONS = 3,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  OP_MODE             mode_in,
  input  logic [CNT_W-1:0]   filter_cnt_in,
  input  logic [CNT_W-1:0]   ifmap_cnt_in,
  pe_array_ctrl_if.slave     src,
  input  logic [NUM_IDX-1:0] sec_free,
  input  logic               pe_error,
  output OP_MODE             mode,
  output logic               change_mode,
  output OP_STAGE            op_stage,
  output PE_IN_PACKET        pe_packet,
  output logic               busy,
  output logic               done,
  output logic               err
);
  localparam int IDX_SPAN = 1 << IDX_W;

  CTRL_STATE          state_q, state_d;
  OP_MODE             mode_q, mode_d;
  logic [CNT_W-1:0]   fcnt_q, fcnt_d, icnt_q, icnt_d, acc_q, acc_d;
  PE_IN_PACKET        pkt_q, pkt_d;

  logic [IDX_SPAN-1:0] idx_oh, avail_pad;
  logic [NUM_IDX-1:0]  avail, consume;
  logic                ovf, credit_ok, idx_bad, conv_open, accept;

  // One-hot destination over the full idx space so out-of-range idx is visible.
  assign idx_oh    = IDX_SPAN'(1) << src.src_idx;
  assign avail_pad = IDX_SPAN'(avail);
  assign credit_ok = |(idx_oh & avail_pad);
  assign idx_bad   = |(idx_oh & ~IDX_SPAN'({NUM_IDX{1'b1}}));

  assign conv_open     = (state_q == S_CONV) && (acc_q != icnt_q);
  assign src.src_ready = !pe_error && ((state_q == S_LOAD) || (conv_open && credit_ok));
  assign accept        = src.src_valid && src.src_ready;
  assign consume       = idx_oh[NUM_IDX-1:0] & {NUM_IDX{accept && (state_q == S_CONV)}};

  pe_credit_tracker #(.NUM_IDX(NUM_IDX), .PE_SECTIONS(PE_SECTIONS)) u_credit (
    .clk       (clk),
    .rst       (rst),
    .consume_i (consume),
    .ret_i     (sec_free),
    .avail_o   (avail),
    .ovf_o     (ovf)
  );

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    fcnt_d      = fcnt_q;
    icnt_d      = icnt_q;
    acc_d       = acc_q;
    change_mode = 1'b0;
    done        = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        mode_d  = mode_in;
        fcnt_d  = filter_cnt_in;
        icnt_d  = ifmap_cnt_in;
        acc_d   = '0;
        state_d = S_CFG;
      end
      S_CFG: begin
        change_mode = 1'b1;
        state_d     = (fcnt_q == '0) ? S_CONV : S_LOAD;
      end
      S_LOAD: if (accept) begin
        if (acc_q == fcnt_q - 1'b1) begin
          acc_d   = '0;
          state_d = S_CONV;
        end else begin
          acc_d = acc_q + 1'b1;
        end
      end
      S_CONV: begin
        // Leave one cycle after the last accept so its broadcast stays in CONV.
        if (accept) acc_d = acc_q + 1'b1;
        if (acc_q == icnt_q) state_d = S_DONE;
        if (src.src_valid && idx_bad) state_d = S_ERR;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
    if (pe_error || ovf) state_d = S_ERR;
  end

  // A handshake coinciding with a credit violation is dropped, not broadcast.
  always_comb begin
    pkt_d       = pkt_q;
    pkt_d.valid = 1'b0;
    if (accept && !ovf) begin
      pkt_d.valid      = 1'b1;
      pkt_d.packet_idx = src.src_idx;
      pkt_d.data       = src.src_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      mode_q  <= MODE1;
      fcnt_q  <= '0;
      icnt_q  <= '0;
      acc_q   <= '0;
      pkt_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      fcnt_q  <= fcnt_d;
      icnt_q  <= icnt_d;
      acc_q   <= acc_d;
      pkt_q   <= pkt_d;
    end
  end

  assign mode      = mode_q;
  assign op_stage  = stage_of(state_q);
  assign pe_packet = pkt_q;
  assign busy      = (state_q != S_IDLE);
  assign err       = (state_q == S_ERR);
endmodule

// File: tb/tb_pe_array_ctrl.sv
// Bench for pe_array_ctrl: job table, hand-built corner sequences and random
// jobs checked against a credit/packet reference model.
module tb_pe_array_ctrl;
  import pe_pkg::*;
  localparam int NUM_IDX = 16;
  localparam int PS      = 3;
  localparam int CNT_W   = 16;
  localparam int DW      = 4*IFDATA_SIZE;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic               start;
  OP_MODE             mode_in;
  logic [CNT_W-1:0]   fc_in, ic_in;
  logic [NUM_IDX-1:0] sec_free;
  logic               pe_error;
  OP_MODE             mode;
  logic               change_mode, busy, done, err;
  OP_STAGE            op_stage;
  PE_IN_PACKET        pe_packet;

  pe_array_ctrl_if sif();

  pe_array_ctrl #(.NUM_IDX(NUM_IDX), .PE_SECTIONS(PS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .mode_in(mode_in),
    .filter_cnt_in(fc_in), .ifmap_cnt_in(ic_in), .src(sif.slave),
    .sec_free(sec_free), .pe_error(pe_error), .mode(mode),
    .change_mode(change_mode), .op_stage(op_stage), .pe_packet(pe_packet),
    .busy(busy), .done(done), .err(err)
  );

  int checks = 0;
  int failures = 0;
  int cred[NUM_IDX];

  typedef struct {
    OP_MODE m;
    int     fc;
    int     ic;
    int     exp_busy;
    int     exp_pkts;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: cycle budget expired", name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0; mode_in = MODE1; fc_in = '0; ic_in = '0;
    sif.src_valid = 1'b0; sif.src_data = '0; sif.src_idx = '0;
    sec_free = '0; pe_error = 1'b0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ready"},  64'(sif.src_ready), 64'(0));
    chk({tag, "_chmode"}, 64'(change_mode), 64'(0));
    chk({tag, "_pktv"},   64'(pe_packet.valid), 64'(0));
    chk({tag, "_stage"},  64'(op_stage), 64'(IDLE));
    chk({tag, "_mode"},   64'(mode), 64'(MODE1));
    chk({tag, "_busy"},   64'(busy), 64'(0));
    chk({tag, "_done"},   64'(done), 64'(0));
    chk({tag, "_err"},    64'(err), 64'(0));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle_inputs();
    for (int i = 0; i < NUM_IDX; i++) cred[i] = PS;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  task automatic chk_pkt(input string tag, input bit ev, input logic [DW-1:0] ed, input logic [4:0] ei);
    chk({tag, "_pkt_valid"}, 64'(pe_packet.valid), 64'(ev));
    if (ev) begin
      chk({tag, "_pkt_data"}, 64'(pe_packet.data), 64'(ed));
      chk({tag, "_pkt_idx"},  64'(pe_packet.packet_idx), 64'(ei));
    end
  endtask

  // Issue start and check the one-cycle mode load; returns in the first stream cycle.
  task automatic start_job(input OP_MODE m, input int fc, input int ic);
    start = 1'b1; mode_in = m; fc_in = CNT_W'(fc); ic_in = CNT_W'(ic);
    #1;
    chk("start_idle_busy", 64'(busy), 64'(0));
    step();
    idle_inputs();
    #1;
    chk("cfg_change_mode", 64'(change_mode), 64'(1));
    chk("cfg_mode", 64'(mode), 64'(m));
    chk("cfg_busy", 64'(busy), 64'(1));
    chk("cfg_pktv", 64'(pe_packet.valid), 64'(0));
    step();
  endtask

  task automatic run_table_job(input vec_t v);
    int bc, pk, dn, n;
    bit ended;
    start_job(v.m, v.fc, v.ic);
    bc = 1; pk = 0; dn = 0; n = 0; ended = 0;
    for (int c = 0; c < 200; c++) begin
      sif.src_valid = 1'b1;
      sif.src_idx   = 5'(n % NUM_IDX);
      sif.src_data  = DW'(n);
      #1;
      if (!busy) begin ended = 1; break; end
      bc++;
      if (pe_packet.valid) pk++;
      if (done) dn++;
      if (sif.src_ready) n++;
      step();
    end
    idle_inputs();
    if (!ended) timeout("tbl_job");
    chk("tbl_busy_cycles", 64'(bc), 64'(v.exp_busy));
    chk("tbl_packets", 64'(pk), 64'(v.exp_pkts));
    chk("tbl_done_pulses", 64'(dn), 64'(1));
  endtask

  // Reference: filter packets always accepted; ifmap accepted iff count not
  // reached and destination credit > 0; every accept reappears one cycle later.
  task automatic run_rand_job(input OP_MODE m, input int fc, input int ic);
    int rem, idx, budget;
    bit v, acc, prev_acc, last, exp_rdy;
    logic [DW-1:0] d, pd;
    logic [4:0] pi;
    logic [NUM_IDX-1:0] fr;
    start_job(m, fc, ic);
    rem = fc; prev_acc = 0; pd = '0; pi = '0; budget = 0;
    while (rem > 0) begin
      v = ($urandom_range(0, 3) != 0);
      d = DW'($urandom());
      sif.src_valid = v; sif.src_data = d; sif.src_idx = 5'($urandom_range(0, 31));
      #1;
      chk("ld_stage", 64'(op_stage), 64'(LOAD_FILTER));
      chk("ld_ready", 64'(sif.src_ready), 64'(1));
      chk_pkt("ld", prev_acc, pd, pi);
      prev_acc = v;
      if (v) begin pd = d; pi = sif.src_idx; rem--; end
      step();
      if (++budget > 2000) begin timeout("ld_budget"); break; end
    end
    rem = ic; budget = 0;
    forever begin
      last = (rem == 0);
      v    = ($urandom_range(0, 3) != 0);
      idx  = $urandom_range(0, NUM_IDX - 1);
      d    = DW'($urandom());
      fr   = '0;
      for (int i = 0; i < NUM_IDX; i++)
        if (cred[i] < PS && $urandom_range(0, 3) == 0) fr[i] = 1'b1;
      sif.src_valid = v; sif.src_data = d; sif.src_idx = 5'(idx); sec_free = fr;
      #1;
      exp_rdy = (rem > 0) && (cred[idx] > 0);
      chk("cv_stage", 64'(op_stage), 64'(CONV));
      chk("cv_ready", 64'(sif.src_ready), 64'(exp_rdy));
      chk_pkt("cv", prev_acc, pd, pi);
      acc = v && exp_rdy;
      if (acc) begin cred[idx]--; pd = d; pi = 5'(idx); rem--; end
      for (int i = 0; i < NUM_IDX; i++) if (fr[i]) cred[i]++;
      prev_acc = acc;
      step();
      if (last) break;
      if (++budget > 3000) begin timeout("cv_budget"); break; end
    end
    idle_inputs();
    #1;
    chk("done_pulse", 64'(done), 64'(1));
    chk("done_stage", 64'(op_stage), 64'(IDLE));
    chk("done_pktv", 64'(pe_packet.valid), 64'(0));
    step();
    chk("post_done", 64'(done), 64'(0));
    chk("post_busy", 64'(busy), 64'(0));
    chk("post_err", 64'(err), 64'(0));
  endtask

  task automatic drive_pkt(input int idx, input int dat);
    sif.src_valid = 1'b1; sif.src_idx = 5'(idx); sif.src_data = DW'(dat);
  endtask

  task automatic seq_stall();
    start_job(MODE1, 0, 4);
    for (int c = 0; c < 3; c++) begin
      drive_pkt(2, c); #1;
      chk("stall_pre_ready", 64'(sif.src_ready), 64'(1));
      step();
    end
    drive_pkt(2, 3); #1;
    chk("stall_no_credit", 64'(sif.src_ready), 64'(0));
    step();
    sec_free[2] = 1'b1; #1;
    chk("stall_free_cycle", 64'(sif.src_ready), 64'(0));
    step();
    sec_free = '0; #1;
    chk("stall_resume", 64'(sif.src_ready), 64'(1));
    chk("stall_gap_pktv", 64'(pe_packet.valid), 64'(0));
    step();
    sif.src_valid = 1'b0; #1;
    chk_pkt("stall_4th", 1'b1, DW'(3), 5'd2);
    step();
    chk("stall_done", 64'(done), 64'(1));
  endtask

  task automatic seq_simul();
    start_job(MODE2, 0, 6);
    for (int c = 0; c < 2; c++) begin
      drive_pkt(5, c); #1;
      chk("sim_pre_ready", 64'(sif.src_ready), 64'(1));
      step();
    end
    drive_pkt(5, 2); sec_free[5] = 1'b1; #1;
    chk("sim_both_ready", 64'(sif.src_ready), 64'(1));
    step();
    sec_free = '0; drive_pkt(5, 3); #1;
    chk("sim_credit_kept", 64'(sif.src_ready), 64'(1));
    chk("sim_no_err", 64'(err), 64'(0));
    step();
    drive_pkt(5, 4); #1;
    chk("sim_credit_gone", 64'(sif.src_ready), 64'(0));
    chk("sim_still_ok", 64'(err), 64'(0));
  endtask

  task automatic seq_extra_free();
    start_job(MODE1, 0, 4);
    drive_pkt(1, 9); sec_free[0] = 1'b1; #1;
    step();
    sec_free = '0; #1;
    chk("xf_err", 64'(err), 64'(1));
    chk("xf_ready", 64'(sif.src_ready), 64'(0));
    chk("xf_pktv", 64'(pe_packet.valid), 64'(0));
    for (int c = 0; c < 3; c++) begin
      start = 1'b1; drive_pkt(1, c); #1;
      chk("xf_ready_stuck", 64'(sif.src_ready), 64'(0));
      chk("xf_err_sticky", 64'(err), 64'(1));
      step();
    end
  endtask

  task automatic seq_pe_error();
    int seen;
    start_job(MODE4, 0, 10);
    for (int c = 0; c < 7; c++) begin
      drive_pkt(c, 100 + c); #1;
      chk("pe_pre_ready", 64'(sif.src_ready), 64'(1));
      step();
    end
    drive_pkt(7, 107); pe_error = 1'b1; #1;
    chk("pe_err_ready", 64'(sif.src_ready), 64'(0));
    chk_pkt("pe_7th", 1'b1, DW'(106), 5'd6);
    step();
    pe_error = 1'b0; #1;
    chk("pe_err_flag", 64'(err), 64'(1));
    chk("pe_err_pktv", 64'(pe_packet.valid), 64'(0));
    seen = 0;
    for (int c = 0; c < 3; c++) begin
      drive_pkt(8, 108); #1;
      if (sif.src_ready) seen++;
      if (pe_packet.valid) seen++;
      step();
    end
    chk("pe_no_more_traffic", 64'(seen), 64'(0));
  endtask

  task automatic seq_reset_mid_load();
    start_job(MODE3, 5, 2);
    for (int c = 0; c < 2; c++) begin
      drive_pkt(c, c); #1;
      chk("rml_ready", 64'(sif.src_ready), 64'(1));
      step();
    end
    #2;
    rst = 1'b0;
    #1;
    chk_reset_outs("rml");
    idle_inputs();
    for (int i = 0; i < NUM_IDX; i++) cred[i] = PS;
    @(negedge clk);
    rst = 1'b1;
    step();
    run_rand_job(MODE2, 3, 4);
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    for (int i = 0; i < NUM_IDX; i++) cred[i] = PS;
    tbl[0] = '{MODE3, 4, 0, 7, 4};
    tbl[1] = '{MODE1, 0, 0, 3, 0};
    tbl[2] = '{MODE2, 0, 3, 6, 3};
    tbl[3] = '{MODE4, 2, 5, 10, 7};
    tbl[4] = '{MODE1, 1, 1, 5, 2};
    #12;
    chk_reset_outs("por");
    @(negedge clk);
    rst = 1'b1;
    step();

    for (int i = 0; i < 5; i++) run_table_job(tbl[i]);

    do_reset(); seq_stall();
    do_reset(); seq_simul();
    do_reset(); seq_extra_free();
    do_reset(); seq_pe_error();
    do_reset(); seq_reset_mid_load();

    do_reset();
    for (int j = 0; j < 25; j++)
      run_rand_job(OP_MODE'($urandom_range(0, 3)), $urandom_range(0, 6), $urandom_range(0, 24));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
